// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply uses radix-2 Booth recoding over DATA_WIDTH steps; divide uses
// restoring shift/subtract on operand magnitudes with a sign fix-up on the
// final step. The result register only changes on an accepted start
// (cleared) and on the RUN->DONE edge.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      op,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_op;
  logic [W:0]      r_acc;    // Booth partial product (signed) or division remainder
  logic [W-1:0]    r_q;      // multiplier / dividend magnitude, becomes product low / quotient
  logic            r_qm1;    // Booth q(-1) bit
  logic [W-1:0]    r_m;      // multiplicand or divisor magnitude
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic [2*W-1:0]  r_result;
  logic            r_dz_out;

  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [W:0]      w_m_ext;
  logic [W:0]      w_sum;
  logic [W:0]      w_mul_acc;
  logic [W-1:0]    w_mul_q;
  logic            w_mul_qm1;
  logic [W:0]      w_rs;
  logic            w_ge;
  logic [W:0]      w_div_acc;
  logic [W-1:0]    w_div_q;
  logic [W-1:0]    w_quot;
  logic [W-1:0]    w_rem;
  logic            w_last;

  assign w_a_mag = a[W-1] ? (~a + 1'b1) : a;
  assign w_b_mag = b[W-1] ? (~b + 1'b1) : b;
  assign w_last  = (r_cnt == CW'(W - 1));

  // One iteration of both datapaths; the FSM picks the one matching r_op.
  always_comb begin
    w_m_ext = {r_m[W-1], r_m};
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
    w_mul_acc = {w_sum[W], w_sum[W:1]};
    w_mul_q   = {w_sum[0], r_q[W-1:1]};
    w_mul_qm1 = r_q[0];

    w_rs      = {r_acc[W-1:0], r_q[W-1]};
    w_ge      = (w_rs >= {1'b0, r_m});
    w_div_acc = w_ge ? (w_rs - {1'b0, r_m}) : w_rs;
    w_div_q   = {r_q[W-2:0], w_ge};

    w_rem  = r_neg_r ? (~w_div_acc[W-1:0] + 1'b1) : w_div_acc[W-1:0];
    if (r_dz)
      w_quot = '1;
    else if (r_neg_q)
      w_quot = ~w_div_q + 1'b1;
    else
      w_quot = w_div_q;
  end

  // Control FSM, operand capture, iteration and result registration.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_m      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_dz_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_op     <= op;
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_result <= '0;
            r_dz_out <= 1'b0;
            if (op) begin
              r_q     <= w_a_mag;
              r_m     <= w_b_mag;
              r_dz    <= (b == '0);
              r_neg_q <= (a[W-1] ^ b[W-1]) && (b != '0);
              r_neg_r <= a[W-1];
            end else begin
              r_q     <= a;
              r_m     <= b;
              r_dz    <= 1'b0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op) begin
            r_acc <= w_div_acc;
            r_q   <= w_div_q;
          end else begin
            r_acc <= w_mul_acc;
            r_q   <= w_mul_q;
            r_qm1 <= w_mul_qm1;
          end
          if (w_last) begin
            r_state  <= DONE;
            r_result <= r_op ? {w_rem, w_quot} : {w_mul_acc[W-1:0], w_mul_q};
            r_dz_out <= r_op & r_dz;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign div_by_zero = r_dz_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (DATA_WIDTH = 32).
module tb_mul_div_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one operation and wait (bounded) for done; lat = edges after accept.
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int lat);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero});
    end
    vectors++;
    if (result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_result got=%h want=0", result);
    end
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mul();
    int lat;
    logic [31:0] av [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] ev [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                            64'h0000_0000_0000_0001, 64'hC000_0000_8000_0000};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, av[i], bv[i], lat);
      vectors++;
      if (lat !== 32) begin
        miscompares++;
        $display("FAIL mul_latency[%0d] got=%0d want=32", i, lat);
      end
      vectors++;
      if (result !== ev[i] || div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_result[%0d] got=%h dz=%b want=%h dz=0", i, result, div_by_zero, ev[i]);
      end
      @(posedge clock); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_done_pulse[%0d] got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_div();
    int lat;
    logic [31:0] av [5] = '{32'd17, 32'hFFFF_FFEF, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C};
    logic [31:0] bv [5] = '{32'hFFFF_FFFB, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] ev [5] = '{64'h0000_0002_FFFF_FFFD, 64'hFFFF_FFFE_FFFF_FFFD,
                            64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000,
                            64'hFFFF_FF9C_FFFF_FFFF};
    logic        dv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, av[i], bv[i], lat);
      vectors++;
      if (lat !== 32) begin
        miscompares++;
        $display("FAIL div_latency[%0d] got=%0d want=32", i, lat);
      end
      vectors++;
      if (result !== ev[i] || div_by_zero !== dv[i]) begin
        miscompares++;
        $display("FAIL div_result[%0d] got=%h dz=%b want=%h dz=%b", i, result, div_by_zero, ev[i], dv[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_hold();
    logic [63:0] held;
    held = result;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (result !== held || div_by_zero !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL result_hold got=%h dz=%b busy=%b want=%h dz=1 busy=0", result, div_by_zero, busy, held);
    end
    // A new start clears result and div_by_zero on its accept edge.
    op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    vectors++;
    if (result !== 64'h0 || div_by_zero !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_clears got=%h dz=%b busy=%b want=0 dz=0 busy=1", result, div_by_zero, busy);
    end
    repeat (32) @(posedge clock);
    #1;
    vectors++;
    if (result !== 64'd12 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_3x4 got=%h done=%b want=c done=1", result, done);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_start_ignored();
    int lat;
    op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        op = 1'b1; a = 32'd1000; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (lat < 32) begin
        vectors++;
        if (result !== 64'h0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL run_stable[%0d] got=%h busy=%b want=0 busy=1", lat, result, busy);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (lat !== 32 || result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      miscompares++;
      $display("FAIL start_ignored got lat=%0d res=%h want lat=32 res=ffffffffffffffeb", lat, result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_abort();
    int lat;
    int seen_done;
    op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    vectors++;
    if ({busy, done} !== 2'b00 || result !== 64'h0) begin
      miscompares++;
      $display("FAIL abort_immediate got busy=%b done=%b res=%h want 0 0 0", busy, done, result);
    end
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) clear = 1'b1;
      @(posedge clock); #1;
      if (done) seen_done++;
    end
    vectors++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done got done_cycles=%0d busy=%b want 0 0", seen_done, busy);
    end
    run_op(1'b0, 32'd6, 32'd7, lat);
    vectors++;
    if (lat !== 32 || result !== 64'd42) begin
      miscompares++;
      $display("FAIL after_abort got lat=%0d res=%h want lat=32 res=2a", lat, result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int waited;
    run_op(1'b1, 32'd50, 32'd7, lat);
    vectors++;
    if (result !== 64'h0000_0001_0000_0007) begin
      miscompares++;
      $display("FAIL b2b_first got=%h want=0000000100000007", result);
    end
    // Hold start with new operands; the unit must take them once it frees up.
    op = 1'b0; a = 32'hFFFF_FFFE; b = 32'd5; start = 1'b1;
    waited = 0;
    do begin
      @(posedge clock); #1;
      waited++;
    end while (!(busy && result == 64'h0) && waited < 5);
    start = 1'b0;
    vectors++;
    if (waited > 2) begin
      miscompares++;
      $display("FAIL b2b_accept got wait=%0d want<=2", waited);
    end
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    vectors++;
    if (lat !== 32 || result !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      miscompares++;
      $display("FAIL b2b_second got lat=%0d res=%h want lat=32 res=fffffffffffffff6", lat, result);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
